// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: round-robin front-end sharing one byte-wide RAM port
// between a read-only fetch port (I) and a read/write data port (D).
// Each accepted word request becomes one RAM cycle per active byte lane,
// followed by a single response cycle on the owning port.
module ram_access_ctrl #(
    parameter int unsigned AW        = 24,
    parameter int unsigned RAM_BYTES = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic          i_resp_valid,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_valid,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_strb,
    output logic          d_ready,
    output logic          d_resp_valid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);

    localparam int unsigned LANES     = 4;
    localparam int unsigned AW1       = AW + 1;
    localparam logic [AW1-1:0] RAM_LIMIT = AW1'(RAM_BYTES);
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          port_q, port_d;
    logic [AW-1:0] base_q, base_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    mask_q, mask_d;
    logic [1:0]    lane_q, lane_d;
    logic          err_q, err_d;
    logic [31:0]   acc_q, acc_d;

    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]    ram_wdata_q, ram_wdata_d;
    logic          i_resp_valid_q, i_resp_valid_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic          i_err_q, i_err_d;
    logic          d_resp_valid_q, d_resp_valid_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          d_err_q, d_err_d;

    logic [AW-1:0] req_addr_c;
    logic [2:0]    nxt_lane_c;

    // Lowest active lane at or above 'from'; bit 2 flags that one exists
    function automatic logic [2:0] find_lane(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (mask[l] && (3'(l) >= from)) begin
                res = {1'b1, 2'(l)};
            end
        end
        return res;
    endfunction

    // Round-robin grant: a lone requester wins, a tie goes to the port not served last
    assign i_ready = (state_q == IDLE) && i_valid && (!d_valid || (last_grant_q == PORT_D));
    assign d_ready = (state_q == IDLE) && d_valid && (!i_valid || (last_grant_q == PORT_I));
    assign req_addr_c = d_ready ? d_addr : i_addr;

    // Next-state, request latching, lane sequencing and registered output values
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        port_d         = port_q;
        base_d         = base_q;
        write_d        = write_q;
        wdata_d        = wdata_q;
        mask_d         = mask_q;
        lane_d         = lane_q;
        err_d          = err_q;
        acc_d          = acc_q;
        ram_en_d       = 1'b0;
        ram_we_d       = 1'b0;
        ram_addr_d     = '0;
        ram_wdata_d    = '0;
        i_resp_valid_d = 1'b0;
        i_rdata_d      = i_rdata_q;
        i_err_d        = i_err_q;
        d_resp_valid_d = 1'b0;
        d_rdata_d      = d_rdata_q;
        d_err_d        = d_err_q;
        nxt_lane_c     = 3'b000;

        case (state_q)
            IDLE: begin
                if (i_ready || d_ready) begin
                    port_d       = d_ready ? PORT_D : PORT_I;
                    last_grant_d = port_d;
                    base_d       = {req_addr_c[AW-1:2], 2'b00};
                    write_d      = d_ready && d_write;
                    wdata_d      = d_ready ? d_wdata : 32'h0;
                    mask_d       = (d_ready && d_write) ? d_strb : 4'hF;
                    err_d        = {1'b0, req_addr_c} >= RAM_LIMIT;
                    acc_d        = '0;
                    nxt_lane_c   = find_lane(mask_d, 3'd0);
                    if (err_d || !nxt_lane_c[2]) begin
                        state_d = RESP;
                    end else begin
                        state_d = XFER;
                        lane_d  = nxt_lane_c[1:0];
                    end
                end
            end
            XFER: begin
                if (!write_q) begin
                    acc_d[{lane_q, 3'b000} +: 8] = ram_rdata;
                end
                nxt_lane_c = find_lane(mask_q, 3'(lane_q) + 3'd1);
                if (nxt_lane_c[2]) begin
                    lane_d = nxt_lane_c[1:0];
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // RAM strobes for the lane that occupies the coming XFER cycle
        if (state_d == XFER) begin
            ram_en_d    = 1'b1;
            ram_we_d    = write_d;
            ram_addr_d  = base_d | AW'(lane_d);
            ram_wdata_d = wdata_d[{lane_d, 3'b000} +: 8];
        end

        // Response registers load on entry to RESP
        if (state_d == RESP) begin
            if (port_d == PORT_D) begin
                d_resp_valid_d = 1'b1;
                d_rdata_d      = (write_d || err_d) ? 32'h0 : acc_d;
                d_err_d        = err_d;
            end else begin
                i_resp_valid_d = 1'b1;
                i_rdata_d      = err_d ? 32'h0 : acc_d;
                i_err_d        = err_d;
            end
        end
    end

    // State and output registers; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= PORT_D;
            port_q         <= PORT_I;
            base_q         <= '0;
            write_q        <= 1'b0;
            wdata_q        <= '0;
            mask_q         <= '0;
            lane_q         <= '0;
            err_q          <= 1'b0;
            acc_q          <= '0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            i_resp_valid_q <= 1'b0;
            i_rdata_q      <= '0;
            i_err_q        <= 1'b0;
            d_resp_valid_q <= 1'b0;
            d_rdata_q      <= '0;
            d_err_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            port_q         <= port_d;
            base_q         <= base_d;
            write_q        <= write_d;
            wdata_q        <= wdata_d;
            mask_q         <= mask_d;
            lane_q         <= lane_d;
            err_q          <= err_d;
            acc_q          <= acc_d;
            ram_en_q       <= ram_en_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            i_resp_valid_q <= i_resp_valid_d;
            i_rdata_q      <= i_rdata_d;
            i_err_q        <= i_err_d;
            d_resp_valid_q <= d_resp_valid_d;
            d_rdata_q      <= d_rdata_d;
            d_err_q        <= d_err_d;
        end
    end

    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign i_resp_valid = i_resp_valid_q;
    assign i_rdata      = i_rdata_q;
    assign i_err        = i_err_q;
    assign d_resp_valid = d_resp_valid_q;
    assign d_rdata      = d_rdata_q;
    assign d_err        = d_err_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed vector table, multi-cycle corner sequences
// and randomized requests checked against a word/byte memory model.
module tb_ram_access_ctrl;

    localparam int unsigned AW        = 24;
    localparam int unsigned RAM_BYTES = 4096;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic          i_resp_valid;
    logic [31:0]   i_rdata;
    logic          i_err;
    logic          d_valid;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [3:0]    d_strb;
    logic          d_ready;
    logic          d_resp_valid;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    int checks;
    int errors;

    ram_access_ctrl #(.AW(AW), .RAM_BYTES(RAM_BYTES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .i_addr       (i_addr),
        .i_ready      (i_ready),
        .i_resp_valid (i_resp_valid),
        .i_rdata      (i_rdata),
        .i_err        (i_err),
        .d_valid      (d_valid),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_strb       (d_strb),
        .d_ready      (d_ready),
        .d_resp_valid (d_resp_valid),
        .d_rdata      (d_rdata),
        .d_err        (d_err),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM attached to the DUT
    logic [7:0] mem [RAM_BYTES];
    logic       clr_mem;
    assign ram_rdata = mem[ram_addr[11:0]];
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < RAM_BYTES; i++) mem[i] <= 8'h00;
        end else if (ram_en && ram_we) begin
            mem[ram_addr[11:0]] <= ram_wdata;
        end
    end

    // Expected memory contents, updated at request level
    logic [7:0] ref_mem [RAM_BYTES];

    typedef struct {
        logic [AW-1:0] a;
        logic          we;
        logic [7:0]    d;
    } ram_ev_t;
    ram_ev_t ram_log[$];
    int      idle_bad;

    // Record every RAM cycle; flag nonzero strobes while disabled
    always @(negedge clk) begin
        if (ram_en) begin
            ram_log.push_back('{a: ram_addr, we: ram_we, d: ram_wdata});
        end else if (ram_we || (ram_addr != '0) || (ram_wdata != 8'h00)) begin
            idle_bad++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive one request, wait for accept and response; lat counts cycles after accept
    task automatic run_req(input bit port, input bit wr, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [3:0] st,
                           output logic [31:0] rd, output logic er, output int lat);
        bit acc;
        acc = 1'b0;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        @(posedge clk);
        #1;
        if (port) begin
            d_valid = 1'b1; d_write = wr; d_addr = addr; d_wdata = wd; d_strb = st;
        end else begin
            i_valid = 1'b1; i_addr = addr;
        end
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            if (port ? d_ready : i_ready) acc = 1'b1;
            @(posedge clk);
        end
        ram_log.delete();
        #1;
        i_valid = 1'b0;
        d_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout port=%0d addr=%h", port, addr);
            return;
        end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (port ? d_resp_valid : i_resp_valid) begin
                lat = n;
                rd  = port ? d_rdata : i_rdata;
                er  = port ? d_err : i_err;
                break;
            end
        end
    endtask

    // Predict a request's outcome from the memory model, run it, compare, update model
    task automatic verify(input string tag, input bit port, input bit wr, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic er, output int lat);
        bit          ewr;
        bit          eerr;
        logic [11:0] base;
        logic [3:0]  mask;
        int          elat;
        logic [31:0] erd;
        ram_ev_t     exp_q[$];
        ewr  = port && wr;
        eerr = (addr >= AW'(RAM_BYTES));
        base = addr[11:0] & 12'hFFC;
        mask = ewr ? st : 4'hF;
        elat = eerr ? 1 : ($countones(mask) + 1);
        erd  = '0;
        if (!eerr) begin
            for (int l = 0; l < 4; l++) begin
                if (mask[l]) begin
                    exp_q.push_back('{a: AW'(base) + AW'(l), we: ewr, d: wd[8*l +: 8]});
                    if (!ewr) erd[8*l +: 8] = ref_mem[base + 12'(l)];
                end
            end
        end
        run_req(port, wr, addr, wd, st, rd, er, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_err"}, 32'(er), 32'(eerr));
        chk({tag, "_nram"}, 32'(ram_log.size()), 32'(exp_q.size()));
        if (ram_log.size() == exp_q.size()) begin
            for (int k = 0; k < exp_q.size(); k++) begin
                chk($sformatf("%s_ram%0d_addr", tag, k), 32'(ram_log[k].a), 32'(exp_q[k].a));
                chk($sformatf("%s_ram%0d_we", tag, k), 32'(ram_log[k].we), 32'(exp_q[k].we));
                if (exp_q[k].we) chk($sformatf("%s_ram%0d_wdata", tag, k), 32'(ram_log[k].d), 32'(exp_q[k].d));
            end
        end
        if (!eerr && ewr) begin
            for (int l = 0; l < 4; l++) begin
                if (st[l]) ref_mem[base + 12'(l)] = wd[8*l +: 8];
            end
        end
    endtask

    typedef struct {
        bit            port;
        bit            wr;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [3:0]    st;
        logic [31:0]   rd;
        bit            err;
        int            lat;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          ng;
        int          both;
        int          overlap;
        int          resp_seen;
        logic [3:0]  order;
        bit          p;
        bit          w;
        logic [AW-1:0] a;

        checks   = 0;
        errors   = 0;
        idle_bad = 0;
        for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = 8'h00;

        // port: 1 = D, 0 = I
        vecs[0]  = '{1'b1, 1'b1, 24'h000010, 32'hA1B2C3D4, 4'hF, 32'h00000000, 1'b0, 5};
        vecs[1]  = '{1'b0, 1'b0, 24'h000010, 32'h00000000, 4'h0, 32'hA1B2C3D4, 1'b0, 5};
        vecs[2]  = '{1'b1, 1'b1, 24'h000020, 32'h11223344, 4'hA, 32'h00000000, 1'b0, 3};
        vecs[3]  = '{1'b1, 1'b0, 24'h000020, 32'hFFFFFFFF, 4'h0, 32'h11003300, 1'b0, 5};
        vecs[4]  = '{1'b1, 1'b0, 24'h001000, 32'h00000000, 4'hF, 32'h00000000, 1'b1, 1};
        vecs[5]  = '{1'b1, 1'b1, 24'h000030, 32'hDEADBEEF, 4'h0, 32'h00000000, 1'b0, 1};
        vecs[6]  = '{1'b1, 1'b0, 24'h000030, 32'h00000000, 4'hF, 32'h00000000, 1'b0, 5};
        vecs[7]  = '{1'b0, 1'b0, 24'h001003, 32'h00000000, 4'h0, 32'h00000000, 1'b1, 1};
        vecs[8]  = '{1'b1, 1'b1, 24'h000FFC, 32'h0BADF00D, 4'h1, 32'h00000000, 1'b0, 2};
        vecs[9]  = '{1'b1, 1'b0, 24'h000FFF, 32'h00000000, 4'hF, 32'h0000000D, 1'b0, 5};
        vecs[10] = '{1'b0, 1'b0, 24'h000013, 32'h00000000, 4'h0, 32'hA1B2C3D4, 1'b0, 5};
        vecs[11] = '{1'b1, 1'b1, 24'h001000, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1, 1};

        rst_n   = 1'b0;
        clr_mem = 1'b1;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_strb = '0;
        @(posedge clk);
        @(posedge clk);
        #1 clr_mem = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            32'({i_ready, i_resp_valid, i_err, d_ready, d_resp_valid, d_err, ram_en, ram_we}), 32'h0);
        chk("reset_rdata", i_rdata | d_rdata, 32'h0);
        chk("reset_ram_bus", 32'(ram_addr) | 32'(ram_wdata), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vector table
        for (int k = 0; k < 12; k++) begin
            verify($sformatf("vec%0d", k), vecs[k].port, vecs[k].wr, vecs[k].addr,
                   vecs[k].wd, vecs[k].st, rd, er, lat);
            chk($sformatf("vec%0d_tab_rdata", k), rd, vecs[k].rd);
            chk($sformatf("vec%0d_tab_err", k), 32'(er), 32'(vecs[k].err));
            chk($sformatf("vec%0d_tab_lat", k), 32'(lat), 32'(vecs[k].lat));
        end

        // Reset asserted during lane 2 of a full-word write
        @(posedge clk);
        #1;
        d_valid = 1'b1; d_write = 1'b1; d_addr = 24'h000040; d_wdata = 32'h55667788; d_strb = 4'hF;
        @(negedge clk);
        chk("abort_ready", 32'(d_ready), 32'h1);
        @(posedge clk);
        #1 d_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort_lane2_en", 32'(ram_en), 32'h1);
        chk("abort_lane2_addr", 32'(ram_addr), 32'h42);
        rst_n = 1'b0;
        #1;
        chk("abort_en_drop", 32'(ram_en), 32'h0);
        resp_seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (d_resp_valid || i_resp_valid) resp_seen++;
        end
        chk("abort_no_resp", 32'(resp_seen), 32'h0);
        chk("abort_mem40", 32'(mem[12'h040]), 32'h88);
        chk("abort_mem41", 32'(mem[12'h041]), 32'h77);
        chk("abort_mem42", 32'(mem[12'h042]), 32'h00);
        chk("abort_mem43", 32'(mem[12'h043]), 32'h00);
        ref_mem[12'h040] = 8'h88;
        ref_mem[12'h041] = 8'h77;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Both ports held valid: grants must alternate starting with I
        @(posedge clk);
        #1;
        i_valid = 1'b1; i_addr = 24'h000010;
        d_valid = 1'b1; d_write = 1'b0; d_addr = 24'h000020; d_strb = 4'h0;
        ng = 0; both = 0; overlap = 0; order = 4'h0;
        for (int n = 0; n < 80 && ng < 4; n++) begin
            @(negedge clk);
            if (i_ready && d_ready) both++;
            if ((i_ready || d_ready) && ram_en) overlap++;
            if (i_ready) begin
                order[ng] = 1'b0; ng++;
            end else if (d_ready) begin
                order[ng] = 1'b1; ng++;
            end
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        d_valid = 1'b0;
        chk("fair_grants", 32'(ng), 32'd4);
        chk("fair_order", 32'(order), 32'(4'b1010));
        chk("fair_both_ready", 32'(both), 32'h0);
        chk("fair_overlap", 32'(overlap), 32'h0);
        repeat (8) @(posedge clk);

        // Randomized requests against the memory model
        for (int k = 0; k < 40; k++) begin
            p = 1'($urandom_range(0, 1));
            w = p ? 1'($urandom_range(0, 1)) : 1'b0;
            a = AW'($urandom_range(0, 4400));
            verify($sformatf("rnd%0d", k), p, w, a, $urandom, 4'($urandom_range(0, 15)), rd, er, lat);
        end

        chk("ram_idle_zero", 32'(idle_bad), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
